// File: rtl/tx_stream_pkg.sv
// Shared types for the TX frame-buffer read streamer: FSM states and the
// byte/end-of-frame entry carried through the output FIFO.
package tx_stream_pkg;

    localparam int DefAddrWidth = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } fifo_entry_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// Small synchronous FIFO of byte/last entries with flush and occupancy output.
// Pointers reset asynchronously; the storage array carries data only and is not reset.
module tx_byte_fifo
    import tx_stream_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fifo_entry_t                  pushEntry,
    output fifo_entry_t                  headEntry,
    output logic                         notEmpty,
    output logic [$clog2(Depth+1)-1:0]   occupancy
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth+1);

    fifo_entry_t           storage [Depth];
    logic [PtrW-1:0]       rdPtr;
    logic [PtrW-1:0]       wrPtr;
    logic [CntW-1:0]       count;
    logic                  doPop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
    endfunction

    assign notEmpty  = (count != '0);
    assign doPop     = pop && notEmpty;
    assign headEntry = storage[rdPtr];
    assign occupancy = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)  wrPtr <= nextPtr(wrPtr);
            if (doPop) rdPtr <= nextPtr(rdPtr);
            case ({push, doPop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) storage[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/tx_frame_streamer.sv
// Read-side controller for the Ethernet TX frame buffer: walks a descriptor's
// byte range through the 1-cycle-latency read port and streams it to the MAC.
module tx_frame_streamer
    import tx_stream_pkg::*;
#(
    parameter int OutDepth  = 4,
    parameter int AddrWidth = DefAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [AddrWidth-1:0] desc_addr,
    input  logic [AddrWidth-1:0] desc_len,
    input  logic                 abort,
    output logic                 mem_ena,
    output logic [AddrWidth-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic                 done,
    output logic [AddrWidth-1:0] rel_addr,
    output logic                 busy
);

    localparam int OccW = $clog2(OutDepth+1);

    tx_state_e             state;
    tx_state_e             stateNext;
    logic [AddrWidth-1:0]  curAddr;
    logic [AddrWidth-1:0]  remaining;
    logic [AddrWidth-1:0]  relAddrQ;
    logic                  rdVld_p1;
    logic                  rdLast_p1;
    logic                  doneQ;
    logic                  doneNext;
    logic                  accept;
    logic                  issue;
    logic                  abortActive;
    logic                  popLast;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  fifoNotEmpty;
    fifo_entry_t           fifoHead;
    fifo_entry_t           fifoIn;
    logic [OccW-1:0]       occ;
    logic [OccW:0]         pending;

    // Credit check uses registered occupancy and the in-flight flag only,
    // keeping tx_ready out of the mem_ena path.
    assign pending     = {1'b0, occ} + {{OccW{1'b0}}, rdVld_p1};
    assign issue       = (state == STREAM) && (pending < (OccW+1)'(OutDepth));
    assign abortActive = abort && (state != IDLE);
    assign popLast     = fifoNotEmpty && tx_ready && fifoHead.last;

    assign fifoIn.data = mem_rdata;
    assign fifoIn.last = rdLast_p1;
    assign fifoPush    = rdVld_p1 && !abortActive;
    assign fifoPop     = fifoNotEmpty && tx_ready && !abortActive;

    tx_byte_fifo #(
        .Depth (OutDepth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifoPush),
        .pop       (fifoPop),
        .flush     (abortActive),
        .pushEntry (fifoIn),
        .headEntry (fifoHead),
        .notEmpty  (fifoNotEmpty),
        .occupancy (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (desc_valid) begin
                    accept = 1'b1;
                    if (desc_len == '0) doneNext  = 1'b1;
                    else                stateNext = STREAM;
                end
            end
            STREAM: begin
                if (issue && (remaining == AddrWidth'(1))) stateNext = DRAIN;
            end
            DRAIN: begin
                if (popLast) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Abort beats a simultaneous last-byte handshake: no done.
        if (abortActive) begin
            stateNext = IDLE;
            doneNext  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curAddr   <= '0;
            remaining <= '0;
            relAddrQ  <= '0;
            rdVld_p1  <= 1'b0;
            rdLast_p1 <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ     <= doneNext;
            rdVld_p1  <= issue && !abortActive;
            rdLast_p1 <= issue && (remaining == AddrWidth'(1));
            if (accept) begin
                curAddr   <= desc_addr;
                remaining <= desc_len;
                relAddrQ  <= desc_addr + desc_len;
            end else if (issue) begin
                curAddr   <= curAddr + AddrWidth'(1);
                remaining <= remaining - AddrWidth'(1);
            end
        end
    end

    assign desc_ready = (state == IDLE) && !rst;
    assign mem_ena    = issue;
    assign mem_addr   = curAddr;
    assign tx_valid   = fifoNotEmpty;
    assign tx_data    = fifoNotEmpty ? fifoHead.data : 8'h00;
    assign tx_last    = fifoNotEmpty && fifoHead.last;
    assign done       = doneQ;
    assign rel_addr   = relAddrQ;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Scoreboard bench for tx_frame_streamer: stimulus queues expected bytes and
// release addresses, a negedge monitor checks every handshake and done pulse.
module tb_tx_frame_streamer;

    localparam int AW = 11;
    localparam int OD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_addr;
    logic [AW-1:0] desc_len;
    logic          abort;
    logic          mem_ena;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready;
    logic          done;
    logic [AW-1:0] rel_addr;
    logic          busy;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t          expQ[$];
    logic [AW-1:0] relQ[$];
    logic [7:0]    bufMem [2048];

    int tests = 0;
    int fails = 0;
    int memEnaCnt = 0;
    int popCnt = 0;
    int outstanding = 0;
    logic pendingDone = 1'b0;
    logic prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic prevLast = 1'b0;

    tx_frame_streamer #(.OutDepth(OD), .AddrWidth(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .abort      (abort),
        .mem_ena    (mem_ena),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .done       (done),
        .rel_addr   (rel_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) bufMem[i] = 8'(i);
    end

    always @(posedge clk) begin
        if (mem_ena) mem_rdata <= bufMem[mem_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: values seen at negedge are what the next posedge samples.
    always @(negedge clk) begin
        exp_t e;
        logic [AW-1:0] r;
        logic nextDone;
        if (rst) begin
            outstanding = 0;
            pendingDone = 1'b0;
            prevHold    = 1'b0;
        end else begin
            nextDone = 1'b0;
            if (done || pendingDone) begin
                tests++;
                if (done !== pendingDone) begin
                    fails++;
                    $display("FAIL done_pulse: actual=%0b required=%0b", done, pendingDone);
                end else if (relQ.size() == 0) begin
                    fails++;
                    $display("FAIL rel_addr: actual=%0h required=<none queued>", rel_addr);
                end else begin
                    r = relQ.pop_front();
                    if (rel_addr !== r) begin
                        fails++;
                        $display("FAIL rel_addr: actual=%0h required=%0h", rel_addr, r);
                    end
                end
            end
            if (prevHold) begin
                tests++;
                if (!tx_valid || tx_data !== prevData || tx_last !== prevLast) begin
                    fails++;
                    $display("FAIL hold_stable: actual=v%0b d%0h l%0b required=v1 d%0h l%0b",
                             tx_valid, tx_data, tx_last, prevData, prevLast);
                end
            end
            if (mem_ena) begin
                memEnaCnt++;
                tests++;
                if (outstanding >= OD) begin
                    fails++;
                    $display("FAIL credit: actual outstanding=%0d required <%0d", outstanding, OD);
                end
            end
            if (tx_valid && tx_ready) begin
                popCnt++;
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL byte: actual=%0h/%0b required=<none queued>", tx_data, tx_last);
                end else begin
                    e = expQ.pop_front();
                    if (tx_data !== e.d || tx_last !== e.l) begin
                        fails++;
                        $display("FAIL byte: actual=%0h/%0b required=%0h/%0b", tx_data, tx_last, e.d, e.l);
                    end
                    if (e.l) nextDone = 1'b1;
                end
            end
            if (desc_valid && desc_ready && desc_len == '0) nextDone = 1'b1;
            if (abort && busy) begin
                outstanding = 0;
                prevHold    = 1'b0;
                nextDone    = 1'b0;
            end else begin
                outstanding = outstanding + int'(mem_ena) - int'(tx_valid && tx_ready);
                prevHold    = tx_valid && !tx_ready;
                prevData    = tx_data;
                prevLast    = tx_last;
            end
            pendingDone = nextDone;
        end
    end

    task automatic pushBytes(input logic [AW-1:0] a, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d = bufMem[(int'(a) + k) % 2048];
            e.l = (k == n - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic pushLit(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        expQ.push_back(e);
    endtask

    // Returns at handshake edge + 1.
    task automatic sendDesc(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        @(posedge clk); #1;
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_len   = l;
        while (!desc_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!desc_ready) begin
            fails++;
            $display("FAIL desc_accept: actual desc_ready=0 required=1 within 50 cycles");
            desc_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (busy || expQ.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: actual busy=%0b left=%0d required busy=0 left=0", name, busy, expQ.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        abort      = 1'b0;
        tx_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_desc_ready", 32'(desc_ready), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_mem_ena", 32'(mem_ena), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rel_addr", 32'(rel_addr), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_desc_ready", 32'(desc_ready), 1);

        // Basic frame with exact latency
        tx_ready = 1'b1;
        pushLit(8'h10, 1'b0); pushLit(8'h11, 1'b0); pushLit(8'h12, 1'b0); pushLit(8'h13, 1'b1);
        relQ.push_back(11'h014);
        sendDesc(11'h010, 11'd4);
        chk("t1_mem_ena_e0", 32'(mem_ena), 1);
        chk("t1_mem_addr_e0", 32'(mem_addr), 32'h010);
        chk("t1_valid_e0", 32'(tx_valid), 0);
        @(posedge clk); #1;
        chk("t1_valid_e1", 32'(tx_valid), 0);
        @(posedge clk); #1;
        chk("t1_valid_e2", 32'(tx_valid), 1);
        chk("t1_data_e2", 32'(tx_data), 32'h10);
        for (int k = 3; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("t1_sustained_valid", 32'(tx_valid), 1);
        end
        chk("t1_last_data", 32'(tx_data), 32'h13);
        chk("t1_last_flag", 32'(tx_last), 1);
        @(posedge clk); #1;
        chk("t1_done", 32'(done), 1);
        chk("t1_rel_addr", 32'(rel_addr), 32'h014);
        chk("t1_desc_ready", 32'(desc_ready), 1);
        waitIdle("t1");

        // Address wrap
        pushLit(8'hFE, 1'b0); pushLit(8'hFF, 1'b0); pushLit(8'h00, 1'b0); pushLit(8'h01, 1'b1);
        relQ.push_back(11'h002);
        sendDesc(11'h7FE, 11'd4);
        waitIdle("wrap");

        // Empty frame
        relQ.push_back(11'h123);
        base = memEnaCnt;
        sendDesc(11'h123, 11'd0);
        chk("len0_done", 32'(done), 1);
        chk("len0_rel_addr", 32'(rel_addr), 32'h123);
        chk("len0_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("len0_done_single", 32'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0_no_reads", 32'(memEnaCnt - base), 0);

        // Backpressure: tx_ready alternates every cycle
        pushBytes(11'h100, 16);
        relQ.push_back(11'h110);
        base = popCnt;
        sendDesc(11'h100, 11'd16);
        n = 0;
        while ((busy || expQ.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            tx_ready = ~tx_ready;
            n++;
        end
        tx_ready = 1'b1;
        waitIdle("bp");
        chk("bp_byte_count", 32'(popCnt - base), 16);

        // Abort after 5 of 64 bytes
        pushBytes(11'h200, 64);
        relQ.push_back(11'h240);
        base = popCnt;
        sendDesc(11'h200, 11'd64);
        n = 0;
        while ((popCnt - base) < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tx_ready = 1'b0;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        expQ.delete();
        relQ.delete();
        chk("abort_popped", 32'(popCnt - base), 5);
        chk("abort_tx_valid", 32'(tx_valid), 0);
        chk("abort_desc_ready", 32'(desc_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pushLit(8'h00, 1'b0); pushLit(8'h01, 1'b1);
        relQ.push_back(11'h302);
        sendDesc(11'h300, 11'd2);
        waitIdle("post_abort");

        // Asynchronous reset mid-frame
        pushBytes(11'h400, 64);
        relQ.push_back(11'h440);
        sendDesc(11'h400, 11'd64);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_tx_last", 32'(tx_last), 0);
        chk("arst_mem_ena", 32'(mem_ena), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_desc_ready", 32'(desc_ready), 0);
        chk("arst_rel_addr", 32'(rel_addr), 0);
        expQ.delete();
        relQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_idle_after", 32'(busy), 0);
        pushLit(8'hFF, 1'b0); pushLit(8'h00, 1'b0); pushLit(8'h01, 1'b1);
        relQ.push_back(11'h002);
        sendDesc(11'h7FF, 11'd3);
        waitIdle("post_rst");
        chk("rel_queue_drained", 32'(relQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
